// File: rtl/chu_als_sampler_core.sv
// chu_als_sampler_core
// FPro slot core that periodically (or on demand) reads an 8-bit light
// sample from a PMOD ALS ADC over a 3-wire SPI link. It keeps the last
// sample with a new-sample flag and a running block average.
//
// Frame timing, in system clocks (D = CLK_DIV):
//   SETUP : D clocks with cs_n low and sclk high
//   SHIFT : 16 sclk periods (D low, D high), then one extra D-clock
//           high half-period so cs_n stays low after the last rising edge
//   HOLD  : D clocks with cs_n high
// cs_n is therefore low for 34*D clocks per frame.
module chu_als_sampler_core #(
    parameter int CLK_DIV = 13,
    parameter int AVG_LOG = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        als_sclk,
    output logic        als_cs_n,
    input  logic        als_miso
);

    localparam int              ACC_W      = 8 + AVG_LOG;
    localparam int              CNT_W      = AVG_LOG + 1;
    localparam logic [7:0]      DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [5:0]      HP_LAST    = 6'd32;
    localparam logic [23:0]     PERIOD_RST = 24'd100000;
    localparam logic [23:0]     PERIOD_MIN = 24'd64;
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'((1 << AVG_LOG) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    // sequencer state
    state_t      state_reg, state_next;
    logic [7:0]  div_reg, div_next;
    logic [5:0]  hp_reg, hp_next;       // half-period index inside SHIFT
    logic [15:0] shift_reg;
    logic [23:0] period_cnt_reg;
    logic        als_cs_n_reg, als_sclk_reg;

    // software-visible state
    logic        enable_reg;
    logic [23:0] period_reg;
    logic [7:0]  sample_reg;
    logic        flag_reg;
    logic [7:0]  avg_reg;
    logic        avg_valid_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] acc_cnt_reg;

    // decoded strobes and helpers
    logic        wr_ctrl, wr_period, rd_status;
    logic        trig_req, en_rise;
    logic        div_end;
    logic        frame_start, sclk_rise, frame_done;
    logic        busy;
    logic        cs_n_next, sclk_next;
    logic [23:0] eff_period;
    logic [7:0]  sample_new;
    logic [ACC_W-1:0] acc_sum, acc_shift;
    logic [31:0] reg_word [4];
    logic [31:0] rd_term  [4];
    logic        unused_bits;

    assign wr_ctrl    = cs && write && (addr == 5'd2);
    assign wr_period  = cs && write && (addr == 5'd3);
    assign rd_status  = cs && read  && (addr == 5'd0);
    assign trig_req   = wr_ctrl && wr_data[1];
    assign en_rise    = wr_ctrl && wr_data[0] && !enable_reg;
    assign div_end    = (div_reg == DIV_LAST);
    assign busy       = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT) ||
                        (state_reg == ST_HOLD);
    assign eff_period = (period_reg < PERIOD_MIN) ? PERIOD_MIN : period_reg;
    assign sample_new = shift_reg[11:4];
    assign acc_sum    = acc_reg + ACC_W'(sample_new);
    assign acc_shift  = acc_sum >> AVG_LOG;
    assign unused_bits = ^{wr_data[31:24], shift_reg[15:12], shift_reg[3:0], acc_shift};

    // Next-state logic: frame sequencing and conversion scheduling
    always_comb begin
        state_next  = state_reg;
        div_next    = div_reg;
        hp_next     = hp_reg;
        frame_start = 1'b0;
        sclk_rise   = 1'b0;
        frame_done  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (trig_req || en_rise) begin
                    state_next  = ST_SETUP;
                    div_next    = 8'd0;
                    frame_start = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!enable_reg) begin
                    state_next = ST_IDLE;
                end else if (period_cnt_reg == 24'd0) begin
                    state_next  = ST_SETUP;
                    div_next    = 8'd0;
                    frame_start = 1'b1;
                end
            end
            ST_SETUP: begin
                if (div_end) begin
                    state_next = ST_SHIFT;
                    div_next   = 8'd0;
                    hp_next    = 6'd0;
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (div_end) begin
                    div_next = 8'd0;
                    if (hp_reg == HP_LAST) begin
                        state_next = ST_HOLD;
                        frame_done = 1'b1;
                    end else begin
                        hp_next   = hp_reg + 6'd1;
                        // leaving a low half-period means sclk rises now
                        sclk_rise = !hp_reg[0];
                    end
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            ST_HOLD: begin
                if (div_end) begin
                    state_next = enable_reg ? ST_WAIT : ST_IDLE;
                    div_next   = 8'd0;
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // SPI pins are registered from the next state so they change cleanly
    assign cs_n_next = !((state_next == ST_SETUP) || (state_next == ST_SHIFT));
    assign sclk_next = !((state_next == ST_SHIFT) && !hp_next[0] && (hp_next != HP_LAST));

    // State, divider and SPI pin registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            div_reg      <= 8'd0;
            hp_reg       <= 6'd0;
            als_cs_n_reg <= 1'b1;
            als_sclk_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            hp_reg       <= hp_next;
            als_cs_n_reg <= cs_n_next;
            als_sclk_reg <= sclk_next;
        end
    end

    assign als_cs_n = als_cs_n_reg;
    assign als_sclk = als_sclk_reg;

    // Capture MISO MSB-first on the clock where sclk rises
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_reg <= 16'd0;
        end else if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], als_miso};
        end
    end

    // Start-to-start countdown; loaded at each conversion start so a new
    // PERIOD only applies from the next start
    always_ff @(posedge clk) begin
        if (!reset) begin
            period_cnt_reg <= 24'd0;
        end else if (frame_start) begin
            period_cnt_reg <= eff_period - 24'd1;
        end else if (period_cnt_reg != 24'd0) begin
            period_cnt_reg <= period_cnt_reg - 24'd1;
        end
    end

    // Control and period registers written from the slot bus
    always_ff @(posedge clk) begin
        if (!reset) begin
            enable_reg <= 1'b0;
            period_reg <= PERIOD_RST;
        end else begin
            if (wr_ctrl) begin
                enable_reg <= wr_data[0];
            end
            if (wr_period) begin
                period_reg <= wr_data[23:0];
            end
        end
    end

    // Last sample and new-sample flag; a frame end wins over a clearing read
    always_ff @(posedge clk) begin
        if (!reset) begin
            sample_reg <= 8'd0;
            flag_reg   <= 1'b0;
        end else if (frame_done) begin
            sample_reg <= sample_new;
            flag_reg   <= 1'b1;
        end else if (rd_status) begin
            flag_reg   <= 1'b0;
        end
    end

    // Block averager: the window-closing sample is folded into the result
    // and the accumulator restarts empty
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_reg       <= '0;
            acc_cnt_reg   <= '0;
            avg_reg       <= 8'd0;
            avg_valid_reg <= 1'b0;
        end else if (frame_done) begin
            if (acc_cnt_reg == WIN_LAST) begin
                avg_reg       <= acc_shift[7:0];
                avg_valid_reg <= 1'b1;
                acc_reg       <= '0;
                acc_cnt_reg   <= '0;
            end else begin
                acc_reg       <= acc_sum;
                acc_cnt_reg   <= acc_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Register view; forced to reset values while reset is held
    always_comb begin
        if (!reset) begin
            reg_word[0] = 32'd0;
            reg_word[1] = 32'd0;
            reg_word[2] = 32'd0;
            reg_word[3] = {8'd0, PERIOD_RST};
        end else begin
            reg_word[0] = {22'd0, busy, flag_reg, sample_reg};
            reg_word[1] = {23'd0, avg_valid_reg, avg_reg};
            reg_word[2] = {31'd0, enable_reg};
            reg_word[3] = {8'd0, period_reg};
        end
    end

    // One-hot read select; addresses 4..31 match no term and read 0
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_term
            assign rd_term[gi] = (addr == 5'(gi)) ? reg_word[gi] : 32'd0;
        end
    endgenerate

    // OR the selected term onto the read bus
    always_comb begin
        rd_data = 32'd0;
        for (int i = 0; i < 4; i++) begin
            rd_data = rd_data | rd_term[i];
        end
    end

endmodule

// File: tb/tb_chu_als_sampler_core.sv
// Directed bench for chu_als_sampler_core (default CLK_DIV=13, AVG_LOG=2).
// Includes a PMOD ALS sensor model that presents a 16-bit word MSB-first.
module tb_chu_als_sampler_core;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        cs       = 1'b0;
    logic        read     = 1'b0;
    logic        write    = 1'b0;
    logic [4:0]  addr     = 5'd0;
    logic [31:0] wr_data  = 32'd0;
    logic [31:0] rd_data;
    logic        als_sclk;
    logic        als_cs_n;
    logic        als_miso = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [15:0] sensor_word = 16'h0000;

    // activity monitor state
    int   cyc      = 0;
    int   fall_cnt = 0;
    int   end_cnt  = 0;
    int   rise_cnt = 0;
    int   low_cnt  = 0;
    int   fall_time [64];
    logic prev_cs_n = 1'b1;
    logic prev_sclk = 1'b1;

    int          smp_tab [8] = '{10, 11, 12, 14, 200, 20, 30, 40};
    logic [31:0] avg_tab [8] = '{32'h000, 32'h000, 32'h000, 32'h10B,
                                 32'h10B, 32'h10B, 32'h10B, 32'h148};

    chu_als_sampler_core dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .als_sclk (als_sclk),
        .als_cs_n (als_cs_n),
        .als_miso (als_miso)
    );

    always #5 clk = ~clk;

    // Pin activity monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (prev_cs_n && !als_cs_n) begin
            fall_time[fall_cnt[5:0]] <= cyc;
            fall_cnt <= fall_cnt + 1;
        end
        if (!prev_cs_n && als_cs_n) end_cnt <= end_cnt + 1;
        if (!als_cs_n) low_cnt <= low_cnt + 1;
        if (!prev_sclk && als_sclk && !als_cs_n) rise_cnt <= rise_cnt + 1;
        prev_cs_n <= als_cs_n;
        prev_sclk <= als_sclk;
    end

    // Sensor model: MSB on cs_n fall, next bit after each sclk rise
    always begin
        @(negedge als_cs_n);
        als_miso = sensor_word[15];
        for (int b = 14; b >= 0; b--) begin
            @(posedge als_sclk or posedge als_cs_n);
            if (als_cs_n) break;
            als_miso = sensor_word[b];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; wr_data = 32'd0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; read = 1'b1; addr = a;
        #1 d = rd_data;
        @(negedge clk);
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic read_check(input logic [4:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] v;
        bus_read(a, v);
        $display("read  addr=%0d data=0x%0h (%s)", a, v, tag);
        check(tag, v, exp);
    endtask

    task automatic wait_end(input int target, input int budget, input string tag);
        int n = 0;
        #1;
        while (end_cnt < target && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check(tag, (end_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_fall(input int target, input int budget, input string tag);
        int n = 0;
        #1;
        while (fall_cnt < target && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check(tag, (fall_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic do_frame(input logic [15:0] w, input string tag);
        int e0;
        sensor_word = w;
        e0 = end_cnt;
        bus_write(5'd2, 32'h2);
        $display("frame word=0x%04h started", w);
        wait_end(e0 + 1, 1000, tag);
        repeat (20) @(negedge clk);
        #1;
    endtask

    initial begin
        int e0, f0, r0, l0;
        logic [31:0] s;

        // ---- reset values while reset is held low ----
        reset = 1'b0;
        repeat (3) @(negedge clk);
        addr = 5'd0; #1 check("rst_rd_addr0", rd_data, 32'd0);
        addr = 5'd1; #1 check("rst_rd_addr1", rd_data, 32'd0);
        addr = 5'd2; #1 check("rst_rd_addr2", rd_data, 32'd0);
        addr = 5'd3; #1 check("rst_rd_addr3", rd_data, 32'd100000);
        addr = 5'd7; #1 check("rst_rd_addr7", rd_data, 32'd0);
        check("rst_cs_n", {31'd0, als_cs_n}, 32'd1);
        check("rst_sclk", {31'd0, als_sclk}, 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // ---- averager: 10,11,12,14 -> 0x10B; unchanged at 5th; 8th updates ----
        for (int i = 0; i < 8; i++) begin
            s = 32'(smp_tab[i]);
            do_frame({4'h0, s[7:0], 4'h0}, "avg_frame_done");
            read_check(5'd0, 32'h100 | s, "avg_sample_flag");
            read_check(5'd1, avg_tab[i], "avg_addr1");
        end
        read_check(5'd2, 32'h0, "trigger_self_clear");
        read_check(5'd9, 32'h0, "unmapped_addr9");

        // ---- single shot of 0x0A50: 16 rises, cs_n low 34*13 clocks ----
        sensor_word = 16'h0A50;
        #1;
        r0 = rise_cnt; l0 = low_cnt; e0 = end_cnt;
        bus_write(5'd2, 32'h2);
        repeat (4) @(negedge clk);
        read_check(5'd0, 32'h228, "busy_in_frame");
        wait_end(e0 + 1, 1000, "shot_done");
        repeat (20) @(negedge clk);
        #1;
        $display("shot  rises=%0d low_clocks=%0d", rise_cnt - r0, low_cnt - l0);
        check("sclk_rises", 32'(rise_cnt - r0), 32'd16);
        check("cs_low_clocks", 32'(low_cnt - l0), 32'd442);
        read_check(5'd0, 32'h1A5, "shot_first_read");
        read_check(5'd0, 32'h0A5, "shot_second_read");

        // ---- flag set and clearing read on the same clock ----
        sensor_word = 16'h0330;
        #1;
        e0 = end_cnt;
        bus_write(5'd2, 32'h2);
        repeat (441) @(negedge clk);
        #1;
        check("collide_still_low", 32'(end_cnt - e0), 32'd0);
        cs = 1'b1; read = 1'b1; addr = 5'd0;
        @(negedge clk);
        cs = 1'b0; read = 1'b0;
        #1;
        check("collide_frame_end", 32'(end_cnt - e0), 32'd1);
        repeat (20) @(negedge clk);
        read_check(5'd0, 32'h133, "collide_flag_kept");
        read_check(5'd0, 32'h033, "collide_flag_cleared");

        // ---- trigger while busy, enable cleared mid-frame ----
        sensor_word = 16'h0C30;
        #1;
        f0 = fall_cnt; e0 = end_cnt;
        bus_write(5'd2, 32'h2);
        repeat (100) @(negedge clk);
        bus_write(5'd2, 32'h3);
        repeat (100) @(negedge clk);
        bus_write(5'd2, 32'h0);
        wait_end(e0 + 1, 1000, "busy_trig_done");
        repeat (600) @(negedge clk);
        #1;
        check("busy_trig_one_frame", 32'(fall_cnt - f0), 32'd1);
        read_check(5'd0, 32'h1C3, "busy_trig_idle");
        read_check(5'd2, 32'h0, "busy_trig_ctrl");

        // ---- periodic mode, PERIOD=1000, 8 frames ----
        sensor_word = 16'h0770;
        bus_write(5'd3, 32'd1000);
        #1;
        f0 = fall_cnt;
        bus_write(5'd2, 32'h1);
        wait_fall(f0 + 8, 10000, "periodic_8_frames");
        bus_write(5'd2, 32'h0);
        for (int i = 0; i < 7; i++) begin
            $display("period interval %0d = %0d clocks", i,
                     fall_time[(f0 + i + 1) % 64] - fall_time[(f0 + i) % 64]);
            check("period_1000", 32'(fall_time[(f0 + i + 1) % 64] - fall_time[(f0 + i) % 64]),
                  32'd1000);
        end
        repeat (1200) @(negedge clk);
        #1;
        check("periodic_stopped", 32'(fall_cnt - f0), 32'd8);
        read_check(5'd0, 32'h177, "periodic_last_sample");
        read_check(5'd3, 32'd1000, "period_readback");

        // ---- reset mid-SHIFT ----
        sensor_word = 16'h0A50;
        bus_write(5'd2, 32'h2);
        repeat (230) @(negedge clk);
        #1;
        check("midframe_cs_low", {31'd0, als_cs_n}, 32'd0);
        check("midframe_sclk_low", {31'd0, als_sclk}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("abort_cs_n", {31'd0, als_cs_n}, 32'd1);
        check("abort_sclk", {31'd0, als_sclk}, 32'd1);
        addr = 5'd1; #1 check("abort_rd_addr1_held", rd_data, 32'd0);
        addr = 5'd3; #1 check("abort_rd_addr3_held", rd_data, 32'd100000);
        @(negedge clk);
        reset = 1'b1;
        read_check(5'd0, 32'd0, "after_rst_addr0");
        read_check(5'd1, 32'd0, "after_rst_addr1");
        read_check(5'd2, 32'd0, "after_rst_addr2");
        read_check(5'd3, 32'd100000, "after_rst_addr3");

        // ---- PERIOD=10 is clamped; frame length then sets the pace ----
        bus_write(5'd3, 32'd10);
        #1;
        f0 = fall_cnt;
        bus_write(5'd2, 32'h1);
        wait_fall(f0 + 3, 3000, "short_period_frames");
        bus_write(5'd2, 32'h0);
        for (int i = 0; i < 2; i++) begin
            $display("short period interval %0d = %0d clocks", i,
                     fall_time[(f0 + i + 1) % 64] - fall_time[(f0 + i) % 64]);
            check("short_period", 32'(fall_time[(f0 + i + 1) % 64] - fall_time[(f0 + i) % 64]),
                  32'd456);
        end
        repeat (600) @(negedge clk);
        read_check(5'd0, 32'h1A5, "short_period_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
